// File: rtl/sysid_read_arbiter.sv
// Two-requester round-robin read arbiter in front of a SysID slave (timestamp/ID words).
// Define SYSID_CHECK_EN to build the sticky ID-word mismatch detector.
module sysid_read_arbiter #(
  parameter logic [31:0] EXPECTED_ID = 32'h6073820E
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        addr0,
  input  logic        addr1,
  output logic        valid0,
  output logic        valid1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  output logic [15:0] read_count,
  output logic        id_mismatch,
  output logic [1:0]  fsm_state
);

  // Handshake: a requester raises reqN (with addrN) and holds it until validN;
  // validN is a one-cycle pulse with rdata valid, and reqN must drop on the edge
  // ending that pulse, otherwise the next IDLE cycle starts a new transaction.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        ptr;
  logic        winner;
  logic        grant1;
  logic [15:0] count_q;

  // Requester 1 wins when alone, or on a tie when the pointer names it.
  assign grant1     = req1 & (~req0 | ptr);
  assign read_count = count_q;
  assign fsm_state  = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      winner        <= 1'b0;
      sysid_address <= 1'b0;
      rdata         <= 32'h0;
      valid0        <= 1'b0;
      valid1        <= 1'b0;
      busy          <= 1'b0;
      count_q       <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner        <= grant1;
            sysid_address <= grant1 ? addr1 : addr0;
            busy          <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          rdata  <= sysid_readdata;
          valid0 <= ~winner;
          valid1 <= winner;
          state  <= DONE;
        end
        DONE: begin
          valid0  <= 1'b0;
          valid1  <= 1'b0;
          busy    <= 1'b0;
          count_q <= count_q + 16'd1;
          ptr     <= ~winner;
          state   <= IDLE;
        end
        default: begin
          valid0 <= 1'b0;
          valid1 <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef SYSID_CHECK_EN
  // Sticky: once a bad ID word has been seen only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      id_mismatch <= 1'b0;
    end else if (state == READ && sysid_address && sysid_readdata != EXPECTED_ID) begin
      id_mismatch <= 1'b1;
    end
  end
`else
  logic unused_expected_id;
  assign unused_expected_id = ^EXPECTED_ID;
  assign id_mismatch        = 1'b0;
`endif

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Directed bench for sysid_read_arbiter: vector table of single transactions plus
// hand-written contention, back-to-back, mismatch, reset-abort and wrap sequences.
module tb_sysid_read_arbiter;

  localparam logic [31:0] ID_WORD = 32'h6073820E;
  localparam logic [31:0] TS_WORD = 32'h0001F00D;

  logic        clock;
  logic        reset;
  logic        req0, req1, addr0, addr1;
  logic        valid0, valid1;
  logic [31:0] rdata;
  logic        busy;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic [15:0] read_count;
  logic        id_mismatch;
  logic [1:0]  fsm_state;

  logic [31:0] ts_word, id_word;
  logic [15:0] exp_count;
  logic        exp_mm;
  int          checks, failures;

  typedef struct {
    logic        r0, r1, a0, a1;
    logic        v0, v1;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[7];

  // SysID slave model: read data is combinational from the address.
  assign sysid_readdata = sysid_address ? id_word : ts_word;

  sysid_read_arbiter dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .valid0(valid0), .valid1(valid1), .rdata(rdata), .busy(busy),
    .sysid_address(sysid_address), .sysid_readdata(sysid_readdata),
    .read_count(read_count), .id_mismatch(id_mismatch), .fsm_state(fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = 1'b0; addr1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_count = 16'h0;
  endtask

  // One full transaction starting in an IDLE cycle; addr flips and slave data
  // changes after acceptance/capture must not disturb the result.
  task automatic run_txn(input vec_t v, input string name);
    logic [31:0] ts_save, id_save;
    req0 = v.r0; req1 = v.r1; addr0 = v.a0; addr1 = v.a1;
    check({name, " idle busy"}, {31'h0, busy}, 32'h0);
    tick();
    check({name, " read busy"}, {31'h0, busy}, 32'h1);
    check({name, " read state"}, {30'h0, fsm_state}, 32'h1);
    check({name, " read valid"}, {30'h0, valid0, valid1}, 32'h0);
    check({name, " address"}, {31'h0, sysid_address}, {31'h0, v.v0 ? v.a0 : v.a1});
    addr0 = ~v.a0; addr1 = ~v.a1;
    tick();
    check({name, " valid0"}, {31'h0, valid0}, {31'h0, v.v0});
    check({name, " valid1"}, {31'h0, valid1}, {31'h0, v.v1});
    check({name, " rdata"}, rdata, v.rd);
    ts_save = ts_word; id_save = id_word;
    ts_word = ~ts_word; id_word = ~id_word;
    req0 = 1'b0; req1 = 1'b0;
    exp_count = exp_count + 16'd1;
    tick();
    check({name, " after valid"}, {30'h0, valid0, valid1}, 32'h0);
    check({name, " after busy"}, {31'h0, busy}, 32'h0);
    check({name, " rdata hold"}, rdata, v.rd);
    check({name, " count"}, {16'h0, read_count}, {16'h0, exp_count});
    ts_word = ts_save; id_word = id_save;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ts_word = TS_WORD;
    id_word = ID_WORD;
`ifdef SYSID_CHECK_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    //          r0    r1    a0    a1    v0    v1    rdata
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ID_WORD};  // single read, ptr->1
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ID_WORD};  // tie, ptr=1 -> req1
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, TS_WORD};  // tie, ptr=0 -> req0
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, ID_WORD};  // lone req0 with ptr=1
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, TS_WORD};  // tie, ptr=1 -> req1
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, TS_WORD};  // lone req1 with ptr=0
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, ID_WORD};  // tie, ptr=0 -> req0

    // Reset dominates live requests.
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 1'b1; addr1 = 1'b1;
    tick();
    tick();
    check("reset state", {30'h0, fsm_state}, 32'h0);
    check("reset valid", {30'h0, valid0, valid1}, 32'h0);
    check("reset busy", {31'h0, busy}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    check("reset count", {16'h0, read_count}, 32'h0);
    check("reset address", {31'h0, sysid_address}, 32'h0);
    check("reset mismatch", {31'h0, id_mismatch}, 32'h0);
    req0 = 1'b0; req1 = 1'b0; addr0 = 1'b0; addr1 = 1'b0;
    reset = 1'b0;
    exp_count = 16'h0;

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));
    check("vec mismatch", {31'h0, id_mismatch}, 32'h0);

    // Contention held for 9 cycles: req0, req1, req0 at 3-cycle spacing.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("tie c%0d valid0", c), {31'h0, valid0}, {31'h0, (c == 2 || c == 8)});
      check($sformatf("tie c%0d valid1", c), {31'h0, valid1}, {31'h0, (c == 5)});
      check($sformatf("tie c%0d state", c), {30'h0, fsm_state}, c % 3);
      if (c == 8) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
    end
    check("tie count", {16'h0, read_count}, 32'd3);
    check("tie idle busy", {31'h0, busy}, 32'h0);

    // Back-to-back reads from req1 alone.
    do_reset();
    begin
      int pulses;
      pulses = 0;
      req1 = 1'b1; addr1 = 1'b0;
      for (int c = 0; c < 9; c++) begin
        check($sformatf("b2b c%0d valid1", c), {31'h0, valid1}, {31'h0, (c % 3 == 2)});
        check($sformatf("b2b c%0d valid0", c), {31'h0, valid0}, 32'h0);
        if (valid1) pulses++;
        if (c == 8) req1 = 1'b0;
        tick();
      end
      check("b2b pulses", pulses, 32'd3);
      check("b2b count", {16'h0, read_count}, 32'd3);
      check("b2b rdata", rdata, TS_WORD);
    end

    // Bad ID word, then a good one: the flag is sticky when the check is built.
    do_reset();
    id_word = 32'hDEADBEEF;
    run_txn('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF}, "bad id");
    check("bad id mismatch", {31'h0, id_mismatch}, {31'h0, exp_mm});
    id_word = ID_WORD;
    run_txn('{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ID_WORD}, "good id");
    check("sticky mismatch", {31'h0, id_mismatch}, {31'h0, exp_mm});

    // Reset while in READ aborts with no pulse and no count.
    req0 = 1'b1; addr0 = 1'b1;
    tick();
    check("abort in read", {30'h0, fsm_state}, 32'h1);
    reset = 1'b1;
    req0 = 1'b0;
    tick();
    check("abort valid", {30'h0, valid0, valid1}, 32'h0);
    check("abort busy", {31'h0, busy}, 32'h0);
    check("abort rdata", rdata, 32'h0);
    check("abort count", {16'h0, read_count}, 32'h0);
    check("abort address", {31'h0, sysid_address}, 32'h0);
    check("abort mismatch", {31'h0, id_mismatch}, 32'h0);
    check("abort state", {30'h0, fsm_state}, 32'h0);
    reset = 1'b0;
    tick();
    check("abort no pulse", {30'h0, valid0, valid1}, 32'h0);
    exp_count = 16'h0;
    run_txn('{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ID_WORD}, "post abort");

    // Counter wrap: preload the count to its maximum, then one more read.
    force dut.count_q = 16'hFFFF;
    tick();
    release dut.count_q;
    tick();
    check("wrap preload", {16'h0, read_count}, 32'h0000FFFF);
    exp_count = 16'hFFFF;
    run_txn('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, TS_WORD}, "wrap");
    check("wrap zero", {16'h0, read_count}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Valid pulses are mutually exclusive and confined to DONE.
  always @(negedge clock) begin
    if (!reset && (valid0 || valid1)) begin
      checks++;
      if ((valid0 && valid1) || fsm_state != 2'd2) begin
        failures++;
        $display("FAIL valid_excl: valid0=%0b valid1=%0b state=%0d required one-hot in DONE",
                 valid0, valid1, fsm_state);
      end
    end
  end

endmodule

// File: doc/sysid_read_arbiter.md
SYSID_READ_ARBITER -- requirements
Module: sysid_read_arbiter

Interface
REQ-001 The block SHALL have one parameter: EXPECTED_ID, default 32'h6073820E, the ID word expected at SysID address 1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1 each  requester read requests; level, held until the matching valid.
REQ-006 addr0, addr1  in  1 each  requester word select: 0 = timestamp word, 1 = ID word.
REQ-007 valid0, valid1  out  1 each  one-cycle pulse; rdata is valid for that requester.
REQ-008 rdata  out  32  captured SysID word; shared by both requesters.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 sysid_address  out  1  registered address to the SysID slave.
REQ-011 sysid_readdata  in  32  SysID slave read data; combinational from sysid_address.
REQ-012 read_count  out  16  count of completed transactions.
REQ-013 id_mismatch  out  1  sticky ID-check flag (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, READ, DONE; every transition is unconditional except the exit from IDLE.
REQ-015 IDLE, req0=req1=0: stay in IDLE.
REQ-016 IDLE, any req high: select winner, latch winner id, load sysid_address from the winner's addr, go to READ.
REQ-017 READ: load rdata from sysid_readdata, go to DONE.
REQ-018 DONE: assert the winner's valid for exactly one cycle, increment read_count, go to IDLE.
REQ-019 Latency: req sampled high in IDLE at cycle N SHALL produce valid at cycle N+2; sustained throughput is one read per 3 cycles.
REQ-020 Arbitration SHALL be round-robin with a 1-bit priority pointer.
REQ-021 On simultaneous req0 and req1, the requester named by the pointer SHALL win.
REQ-022 With a single requester, that requester SHALL win regardless of the pointer.
REQ-023 In DONE, the pointer SHALL be set to the non-winner.
REQ-024 A requester SHALL deassert req on the edge ending its valid cycle; a req still high in the following IDLE cycle SHALL start a new transaction.
REQ-025 req and addr changes outside IDLE SHALL be ignored; addr is sampled only on acceptance.
REQ-026 valid0 and valid1 SHALL never be high together and SHALL never be high outside DONE.
REQ-027 rdata SHALL hold its last captured value until the next READ state.
REQ-028 read_count SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-029 While reset is high, the block SHALL force state=IDLE, pointer=0, sysid_address=0, rdata=0, valid0=valid1=0, busy=0, read_count=0, id_mismatch=0.
REQ-030 Reset asserted in READ or DONE SHALL abort the transaction with no valid pulse and no read_count increment.
REQ-031 The first edge after reset deasserts SHALL be treated as an IDLE cycle.

Configuration
REQ-032 The macro SYSID_CHECK_EN SHALL control the ID check.
REQ-033 SYSID_CHECK_EN defined: in READ with sysid_address=1, id_mismatch SHALL set on the next edge if sysid_readdata != EXPECTED_ID.
REQ-034 SYSID_CHECK_EN defined: id_mismatch SHALL clear only on reset.
REQ-035 SYSID_CHECK_EN undefined: id_mismatch SHALL be constant 0 and no comparator SHALL be built.

Verification
REQ-036 Single read: req0=1, addr0=1, sysid_readdata=32'h6073820E -> valid0 at N+2, rdata=32'h6073820E, read_count=1, id_mismatch=0.
REQ-037 Contention: req0=req1=1 after reset -> valid0 at N+2, then valid1 at N+5; pointer alternates on a continued tie.
REQ-038 Back-to-back: req1 held for 9 cycles -> three valid1 pulses at 3-cycle spacing, read_count=3.
REQ-039 Mismatch, SYSID_CHECK_EN defined: addr0=1, sysid_readdata=32'hDEADBEEF -> id_mismatch=1, still 1 after a later correct read; with the macro undefined it stays 0.
REQ-040 Reset in READ -> no valid pulse, all outputs at reset values on the next cycle, a fresh req completes normally.
REQ-041 Wrap: preload 65535 transactions, issue one more -> read_count=16'h0000.
